// File: rtl/thermo_accum.sv
// thermo_accum: thermometer-code decoder with per-sample level output,
// block accumulator over OSF accepted samples, and a one-deep output
// buffer with ready handshake, sticky bubble and overrun flags.
module thermo_accum #(
  parameter int THERMO_W    = 8,
  parameter int OSF         = 8,
  parameter int BUBBLE_MODE = 0,
  localparam int BIN_W      = $clog2(THERMO_W + 1),
  localparam int SUM_W      = $clog2(THERMO_W * OSF + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Enable,
  input  logic [THERMO_W-1:0] Input,
  input  logic                ClrFlags,
  input  logic                SumReady,
  output logic [BIN_W-1:0]    Level,
  output logic                LevelValid,
  output logic [SUM_W-1:0]    Sum,
  output logic                SumValid,
  output logic                BubbleErr,
  output logic                Overrun
);

  localparam int CNT_W = (OSF > 1) ? $clog2(OSF) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  // Number of set bits in a code.
  function automatic logic [BIN_W-1:0] ones_count(input logic [THERMO_W-1:0] code);
    logic [BIN_W-1:0] n;
    n = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      n = n + BIN_W'(code[i]);
    end
    return n;
  endfunction

  // A legal code is 2^k-1: adding one carries through every set bit, so the
  // AND with its successor is zero only for a contiguous LSB-aligned fill.
  function automatic logic is_thermo(input logic [THERMO_W-1:0] code);
    logic [THERMO_W-1:0] nxt;
    nxt = code + THERMO_W'(1);
    return (code & nxt) == '0;
  endfunction

  // Legal codes decode to their fill count in either mode; illegal codes
  // collapse to zero in strict mode or to their ones count otherwise.
  function automatic logic [BIN_W-1:0] decode(input logic [THERMO_W-1:0] code);
    if (is_thermo(code) || (BUBBLE_MODE != 0)) begin
      return ones_count(code);
    end
    return '0;
  endfunction

  logic [BIN_W-1:0] lvl_p1;
  logic             vld_p1;
  logic             bub_p1;
  logic [SUM_W-1:0] acc_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             last_p1;
  logic [SUM_W-1:0] total_p1;
  logic [SUM_W-1:0] sum_p2;
  logic             ovr_p2;
  logic             load_sum;
  logic             drop_sum;
  logic             sum_vld;
  logic             bub_set;
  buf_state_t       state;
  buf_state_t       state_nxt;

  // ---- stage p0 -> p1: decode the sample ----
  assign bub_set = Enable && !is_thermo(Input);

  // Register the decoded level; it holds while no sample is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= Enable;
      if (Enable) begin
        lvl_p1 <= decode(Input);
      end
    end
  end

  // Sticky bubble flag; a new bubble outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bub_p1 <= 1'b0;
    end else if (bub_set) begin
      bub_p1 <= 1'b1;
    end else if (ClrFlags) begin
      bub_p1 <= 1'b0;
    end
  end

  // ---- stage p1 -> p2: accumulate a block of OSF levels ----
  assign last_p1  = vld_p1 && (cnt_p1 == CNT_W'(OSF - 1));
  assign total_p1 = acc_p1 + SUM_W'(lvl_p1);

  // Accumulator and sample counter advance only on valid levels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else if (vld_p1) begin
      if (last_p1) begin
        acc_p1 <= '0;
        cnt_p1 <= '0;
      end else begin
        acc_p1 <= total_p1;
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  // Output buffer state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output buffer next-state: fill on completion, drain on accept unless
  // a new block completes in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (last_p1) state_nxt = FULL;
      FULL:  if (SumReady && !last_p1) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output buffer actions: load a completed sum or drop it when the
  // buffer is occupied and the consumer is not accepting.
  always_comb begin
    load_sum = 1'b0;
    drop_sum = 1'b0;
    sum_vld  = 1'b0;
    case (state)
      EMPTY: load_sum = last_p1;
      FULL: begin
        sum_vld = 1'b1;
        if (last_p1) begin
          load_sum = SumReady;
          drop_sum = !SumReady;
        end
      end
      default: ;
    endcase
  end

  // Sum register: loads a completed block, otherwise holds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sum_p2 <= '0;
    end else if (load_sum) begin
      sum_p2 <= total_p1;
    end
  end

  // Sticky overrun flag; a drop outranks a clear in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_p2 <= 1'b0;
    end else if (drop_sum) begin
      ovr_p2 <= 1'b1;
    end else if (ClrFlags) begin
      ovr_p2 <= 1'b0;
    end
  end

  assign Level      = lvl_p1;
  assign LevelValid = vld_p1;
  assign BubbleErr  = bub_p1;
  assign Sum        = sum_p2;
  assign SumValid   = sum_vld;
  assign Overrun    = ovr_p2;

endmodule

// File: tb/tb_thermo_accum.sv
// Scoreboard bench for thermo_accum: three instances (strict 8x8,
// ones-count 8x8, strict 4x3) with expected levels and sums queued at
// stimulus time and compared when the DUTs present them.
module tb_thermo_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, clr = 1'b0, rdy = 1'b0, en = 1'b0;
  logic [7:0] din = '0;
  logic       c_en = 1'b0, c_rdy = 1'b0;
  logic [3:0] c_din = '0;

  logic n_rst = 1'b1, n_clr = 1'b0, n_rdy = 1'b0, n_crdy = 1'b0;

  logic [3:0] a_lvl, b_lvl;
  logic       a_lv, b_lv, a_sv, b_sv, a_be, b_be, a_ov, b_ov;
  logic [6:0] a_sum, b_sum;
  logic [2:0] c_lvl;
  logic       c_lv, c_sv, c_be, c_ov;
  logic [3:0] c_sum;

  int n_cmp = 0;
  int n_err = 0;

  int acc [3];
  int cnt [3];
  int drop[3];
  int lq0[$], lq1[$], lq2[$];
  int sq0[$], sq1[$], sq2[$];

  thermo_accum #(.THERMO_W(8), .OSF(8), .BUBBLE_MODE(0)) u_a (
    .CLK(clk), .RST(rst), .Enable(en), .Input(din), .ClrFlags(clr), .SumReady(rdy),
    .Level(a_lvl), .LevelValid(a_lv), .Sum(a_sum), .SumValid(a_sv),
    .BubbleErr(a_be), .Overrun(a_ov));

  thermo_accum #(.THERMO_W(8), .OSF(8), .BUBBLE_MODE(1)) u_b (
    .CLK(clk), .RST(rst), .Enable(en), .Input(din), .ClrFlags(clr), .SumReady(rdy),
    .Level(b_lvl), .LevelValid(b_lv), .Sum(b_sum), .SumValid(b_sv),
    .BubbleErr(b_be), .Overrun(b_ov));

  thermo_accum #(.THERMO_W(4), .OSF(3), .BUBBLE_MODE(0)) u_c (
    .CLK(clk), .RST(rst), .Enable(c_en), .Input(c_din), .ClrFlags(clr), .SumReady(c_rdy),
    .Level(c_lvl), .LevelValid(c_lv), .Sum(c_sum), .SumValid(c_sv),
    .BubbleErr(c_be), .Overrun(c_ov));

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: search for a matching fill count k.
  function automatic int exp_level(input int code, input int w, input int mode);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) if (code[i]) ones++;
    for (int k = 0; k <= w; k++) if (code == ((1 << k) - 1)) return k;
    return (mode != 0) ? ones : 0;
  endfunction

  task automatic accum(input int idx, input int lvl, input int osf);
    acc[idx] += lvl;
    if (cnt[idx] == osf - 1) begin
      if (drop[idx] > 0) drop[idx]--;
      else begin
        case (idx)
          0: sq0.push_back(acc[idx]);
          1: sq1.push_back(acc[idx]);
          default: sq2.push_back(acc[idx]);
        endcase
      end
      acc[idx] = 0;
      cnt[idx] = 0;
    end else begin
      cnt[idx]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0; cnt[i] = 0; drop[i] = 0;
    end
  endtask

  // One cycle: apply inputs just after the rising edge, update the model,
  // return at the falling edge with outputs settled.
  task automatic tick(input logic e, input logic [7:0] d, input logic ce, input logic [3:0] cd);
    int la, lb, lc;
    @(posedge clk);
    #1;
    rst = n_rst; clr = n_clr; rdy = n_rdy; c_rdy = n_crdy;
    en = e; din = d; c_en = ce; c_din = cd;
    if (n_rst) model_reset();
    else begin
      if (e) begin
        la = exp_level(int'(d), 8, 0);
        lb = exp_level(int'(d), 8, 1);
        lq0.push_back(la);
        lq1.push_back(lb);
        accum(0, la, 8);
        accum(1, lb, 8);
      end
      if (ce) begin
        lc = exp_level(int'(cd), 4, 0);
        lq2.push_back(lc);
        accum(2, lc, 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 4'h0);
  endtask

  task automatic feed(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) tick(1'b1, d, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    idle(1);
    n_rst = 1'b0;
    idle(1);
  endtask

  task automatic pulse_clr();
    n_clr = 1'b1;
    idle(1);
    n_clr = 1'b0;
    idle(1);
  endtask

  // Output monitor: compare levels and accepted sums against the queues.
  always @(negedge clk) begin
    if (a_lv) begin
      if (lq0.size() == 0) check_val("a_level_unexpected", 1, 0);
      else check_val("a_level", int'(a_lvl), lq0.pop_front());
    end
    if (b_lv) begin
      if (lq1.size() == 0) check_val("b_level_unexpected", 1, 0);
      else check_val("b_level", int'(b_lvl), lq1.pop_front());
    end
    if (c_lv) begin
      if (lq2.size() == 0) check_val("c_level_unexpected", 1, 0);
      else check_val("c_level", int'(c_lvl), lq2.pop_front());
    end
    if (a_sv && rdy) begin
      if (sq0.size() == 0) check_val("a_sum_unexpected", int'(a_sum), -1);
      else check_val("a_sum", int'(a_sum), sq0.pop_front());
    end
    if (b_sv && rdy) begin
      if (sq1.size() == 0) check_val("b_sum_unexpected", int'(b_sum), -1);
      else check_val("b_sum", int'(b_sum), sq1.pop_front());
    end
    if (c_sv && c_rdy) begin
      if (sq2.size() == 0) check_val("c_sum_unexpected", int'(c_sum), -1);
      else check_val("c_sum", int'(c_sum), sq2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle(1);
    do_reset();
    check_val("rst_level", int'(a_lvl), 0);
    check_val("rst_level_valid", int'(a_lv), 0);
    check_val("rst_sum", int'(a_sum), 0);
    check_val("rst_sum_valid", int'(a_sv), 0);
    check_val("rst_bubble", int'(a_be), 0);
    check_val("rst_overrun", int'(a_ov), 0);

    // Basic block with consumer always ready: one-cycle SumValid pulse.
    n_rdy = 1'b1;
    feed(8, 8'h07);
    idle(1);
    check_val("t1_sv_early", int'(a_sv), 0);
    idle(1);
    check_val("t1_sv_pulse", int'(a_sv), 1);
    check_val("t1_sum", int'(a_sum), 24);
    check_val("t1_lv_idle", int'(a_lv), 0);
    check_val("t1_level_hold", int'(a_lvl), 3);
    idle(1);
    check_val("t1_sv_after", int'(a_sv), 0);

    // Bubble in both decode modes, clear, and set-over-clear priority.
    feed(1, 8'h05);
    idle(1);
    check_val("t2_bubble_strict", int'(a_be), 1);
    check_val("t2_bubble_ones", int'(b_be), 1);
    pulse_clr();
    check_val("t2_clr_strict", int'(a_be), 0);
    check_val("t2_clr_ones", int'(b_be), 0);
    n_clr = 1'b1;
    feed(1, 8'h05);
    n_clr = 1'b0;
    idle(1);
    check_val("t2_set_wins", int'(a_be), 1);
    feed(1, 8'h0F);
    idle(1);
    check_val("t2_legal_no_clear", int'(a_be), 1);
    do_reset();

    // Overrun: second block dropped while the first is held.
    n_rdy = 1'b0;
    feed(8, 8'hFF);
    drop[0] = 1;
    drop[1] = 1;
    feed(8, 8'h01);
    idle(2);
    check_val("t3_sv_held", int'(a_sv), 1);
    check_val("t3_sum_held", int'(a_sum), 64);
    check_val("t3_overrun", int'(a_ov), 1);
    n_rdy = 1'b1;
    idle(1);
    feed(8, 8'h03);
    idle(3);
    check_val("t3_overrun_sticky", int'(a_ov), 1);
    check_val("t3_sv_drained", int'(a_sv), 0);
    pulse_clr();
    check_val("t3_overrun_clr", int'(a_ov), 0);
    do_reset();

    // Completion coincident with accept: no bubble, no drop.
    n_rdy = 1'b0;
    feed(8, 8'h07);
    feed(8, 8'h0F);
    n_rdy = 1'b1;
    idle(1);
    n_rdy = 1'b0;
    idle(1);
    check_val("t4_sv_stays", int'(a_sv), 1);
    check_val("t4_sum_new", int'(a_sum), 32);
    check_val("t4_no_overrun", int'(a_ov), 0);
    n_rdy = 1'b1;
    idle(2);
    check_val("t4_sv_drained", int'(a_sv), 0);

    // Reset mid-block discards the partial accumulation.
    feed(5, 8'h0F);
    do_reset();
    check_val("t5_level", int'(a_lvl), 0);
    check_val("t5_level_valid", int'(a_lv), 0);
    check_val("t5_sum", int'(a_sum), 0);
    check_val("t5_sum_valid", int'(a_sv), 0);
    feed(8, 8'h0F);
    idle(3);

    // Gapped enables on the 4-bit, 3-sample instance.
    n_crdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 1'b1, 4'hF);
      idle(2);
    end
    check_val("t6_sv", int'(c_sv), 1);
    check_val("t6_sum", int'(c_sum), 12);
    tick(1'b0, 8'h00, 1'b1, 4'h3);
    idle(2);
    tick(1'b0, 8'h00, 1'b1, 4'h1);
    idle(2);
    tick(1'b0, 8'h00, 1'b1, 4'h7);
    idle(2);
    check_val("t6_sum2", int'(c_sum), 6);
    idle(2);

    check_val("left_lq0", lq0.size(), 0);
    check_val("left_lq1", lq1.size(), 0);
    check_val("left_lq2", lq2.size(), 0);
    check_val("left_sq0", sq0.size(), 0);
    check_val("left_sq1", sq1.size(), 0);
    check_val("left_sq2", sq2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/thermo_accum.md
THERMO_ACCUM -- requirements
Module: thermo_accum

Interface
REQ-001 SHALL have parameter THERMO_W, default 8, thermometer input width (>=2).
REQ-002 SHALL have parameter OSF, default 8, accepted samples per accumulated sum (>=1).
REQ-003 SHALL have parameter BUBBLE_MODE, default 0: 0 = strict decode, 1 = ones-count decode.
REQ-004 SHALL derive localparams BIN_W = clog2(THERMO_W+1) and SUM_W = clog2(THERMO_W*OSF+1).
REQ-005 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Enable  input  1  Input is a valid sample this cycle.
REQ-008 SHALL have port Input  input  THERMO_W  thermometer code, LSB-first fill.
REQ-009 SHALL have port ClrFlags  input  1  clears sticky flags.
REQ-010 SHALL have port SumReady  input  1  consumer accepts Sum.
REQ-011 SHALL have port Level  output  BIN_W  registered per-sample decoded value.
REQ-012 SHALL have port LevelValid  output  1  Level valid this cycle.
REQ-013 SHALL have port Sum  output  SUM_W  accumulated sum of OSF Levels.
REQ-014 SHALL have port SumValid  output  1  Sum holds an unconsumed result.
REQ-015 SHALL have port BubbleErr  output  1  sticky: non-thermometer code seen.
REQ-016 SHALL have port Overrun  output  1  sticky: completed sum dropped.

Function
REQ-017 SHALL treat as a legal code exactly the k lowest bits set, remaining bits clear, for k = 0..THERMO_W.
REQ-018 SHALL, for a legal code, decode Level = k in both modes.
REQ-019 SHALL, for an illegal code, decode Level = 0 if BUBBLE_MODE=0, else Level = number of set bits.
REQ-020 SHALL register Level and set LevelValid = Enable one cycle after sampling (latency 1); with Enable low, LevelValid = 0 and Level holds its last value.
REQ-021 SHALL set BubbleErr one cycle after an Enable cycle with an illegal Input; Input ignored when Enable low.
REQ-022 SHALL keep an accumulator (SUM_W bits) and sample counter (0..OSF-1), advancing only on LevelValid cycles; no overflow possible by construction.
REQ-023 SHALL, on the LevelValid cycle where counter = OSF-1, form the sum acc+Level, clear acc and counter to 0, and attempt to load it into Sum.
REQ-024 SHALL run output buffer FSM with states EMPTY (SumValid=0) and FULL (SumValid=1).
REQ-025 SHALL in EMPTY: on completion load Sum, go FULL; Sum appears 2 cycles after the Enable of the OSF-th sample.
REQ-026 SHALL in FULL: SumValid&&SumReady with no completion -> EMPTY; Sum holds value while not accepted.
REQ-027 SHALL in FULL with completion and SumReady same cycle: load new Sum, stay FULL (no bubble, no drop).
REQ-028 SHALL in FULL with completion and SumReady low: keep old Sum, discard new sum, set Overrun; accumulation continues uninterrupted.
REQ-029 SHALL clear BubbleErr and Overrun on ClrFlags; a set event in the same cycle wins over ClrFlags.
REQ-030 SHALL with OSF=1 load every Level directly into Sum (Sum = Level).

Reset
REQ-031 SHALL on RST high at a rising edge set Level=0, LevelValid=0, Sum=0, SumValid=0, BubbleErr=0, Overrun=0, accumulator=0, counter=0, FSM=EMPTY.
REQ-032 SHALL give RST priority over all inputs; a partial accumulation in progress is discarded; first post-reset sample starts a new block.

Verification
REQ-033 SHALL cover: defaults, Enable held 8 cycles with Input=8'b00000111, SumReady=1 -> Level=3 each cycle, Sum=24 with SumValid pulse 2 cycles after 8th Enable.
REQ-034 SHALL cover: Input=8'b00000101 with BUBBLE_MODE=0 -> Level=0, BubbleErr=1; same with BUBBLE_MODE=1 -> Level=2, BubbleErr=1; ClrFlags -> BubbleErr=0.
REQ-035 SHALL cover: SumReady=0 over two full blocks of 8'b11111111 then 8'b00000001 -> Sum stays 64, Overrun=1; after SumReady=1 next block (all 8'b00000011) yields Sum=16.
REQ-036 SHALL cover: completion and SumReady coincident -> SumValid stays 1, Sum updates to new value, Overrun=0.
REQ-037 SHALL cover: RST asserted after 5 of 8 samples -> all outputs 0; next 8 samples of 8'b00001111 yield Sum=32 (no residue).
REQ-038 SHALL cover: gapped Enable (every third cycle), OSF=3, THERMO_W=4, Input=4'b1111 -> Sum=12 after 3rd accepted sample, counter unaffected by idle cycles.
